// File: rtl/uart_pkg.sv
// Shared UART constants: default FIFO geometry and read-mode selectors.
package uart_pkg;

    localparam int unsigned DATA_SIZE_DEF = 8;
    localparam int unsigned SIZE_FIFO_DEF = 16;

    // Read-port modes for uart_fifo_ext
    localparam bit FWFT_MODE = 1'b1;
    localparam bit REG_MODE  = 1'b0;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_SIZE  = DATA_SIZE_DEF,
    parameter  int unsigned SIZE_FIFO  = SIZE_FIFO_DEF,
    localparam int unsigned ADDR_WIDTH = $clog2(SIZE_FIFO)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_SIZE-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_SIZE-1:0]  rdata
);

    logic [DATA_SIZE-1:0] mem_q [SIZE_FIFO];

    // Write port; storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_fifo_ext.sv
// UART byte FIFO with occupancy count, thresholds, sticky error flags,
// synchronous flush and selectable FWFT / registered read mode.
module uart_fifo_ext
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_SIZE  = DATA_SIZE_DEF,
    parameter  int unsigned SIZE_FIFO  = SIZE_FIFO_DEF,
    parameter  int unsigned AF_LEVEL   = SIZE_FIFO - 4,
    parameter  int unsigned AE_LEVEL   = 4,
    parameter  bit          FWFT       = FWFT_MODE,
    localparam int unsigned ADDR_WIDTH = $clog2(SIZE_FIFO),
    localparam int unsigned CW         = ADDR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_tick,
    input  logic                 clr,
    input  logic [DATA_SIZE-1:0] w_data,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_SIZE-1:0] r_data,
    output logic                 r_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic                 underflow
);

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_acc, wr_acc, mem_we;
    logic [DATA_SIZE-1:0]  mem_rdata;

    // Acceptance decisions use pre-update flags; a read frees a slot for a write when full
    assign rd_acc = rd & ~empty_q;
    assign wr_acc = wr & (~full_q | rd_acc);
    assign mem_we = s_tick & ~clr & wr_acc;

    uart_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .SIZE_FIFO (SIZE_FIFO)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_ptr_q),
        .wdata (w_data),
        .raddr (r_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state for pointers, count and sticky flags; flags re-decode from next count
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (s_tick) begin
            if (clr) begin
                w_ptr_d = '0;
                r_ptr_d = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end else begin
                if (rd && !rd_acc) unf_d = 1'b1;
                if (wr && !wr_acc) ovf_d = 1'b1;
                if (wr_acc) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
                if (rd_acc) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
                count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
            end
        end
        full_d  = (count_d == CW'(SIZE_FIFO));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_LEVEL));
        ae_d    = (count_d <= CW'(AE_LEVEL));
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    if (FWFT == FWFT_MODE) begin : g_fwft
        // Head of queue is visible directly; valid whenever something is stored
        assign r_data  = mem_rdata;
        assign r_valid = ~empty_q;
    end else begin : g_reg
        logic [DATA_SIZE-1:0] r_data_q, r_data_d;
        logic                 r_valid_q, r_valid_d;
        logic                 rd_fire;

        assign rd_fire = s_tick & ~clr & rd_acc;

        // Load the head on an accepted read; valid only for the tick after it
        always_comb begin
            r_data_d  = r_data_q;
            r_valid_d = r_valid_q;
            if (s_tick) begin
                r_valid_d = rd_fire;
                if (rd_fire) r_data_d = mem_rdata;
            end
        end

        // Read data register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else begin
                r_data_q  <= r_data_d;
                r_valid_q <= r_valid_d;
            end
        end

        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Directed testbench for uart_fifo_ext: FWFT instance plus a registered-mode instance.
module tb_uart_fifo_ext;

    logic       clk = 1'b0;
    logic       reset_n, s_tick, clr, wr, rd;
    logic [7:0] w_data;

    logic [7:0] r_data, r_data_r;
    logic       r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic       r_valid_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic [4:0] count, count_r;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_fifo_ext #(.FWFT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .clr(clr), .w_data(w_data),
        .wr(wr), .rd(rd), .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    uart_fifo_ext #(.FWFT(1'b0)) dut_r (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .clr(clr), .w_data(w_data),
        .wr(wr), .rd(rd), .r_data(r_data_r), .r_valid(r_valid_r), .full(full_r), .empty(empty_r),
        .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
        .overflow(ovf_r), .underflow(unf_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        wr = 1'b1; w_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic do_read();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
        tests_run++; if (almost_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
        tests_run++; if (r_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 0", r_valid); end
        tests_run++; if (r_valid_r !== 1'b0 || r_data_r !== 8'h00) begin tests_failed++; $display("FAIL reset_regmode: got valid=%b data=%0h expected 0/00", r_valid_r, r_data_r); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            do_write(8'(i));
            tests_run++; if (count !== 5'(i)) begin tests_failed++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
            tests_run++; if (almost_full !== (i >= 12)) begin tests_failed++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i >= 12)); end
            tests_run++; if (full !== (i == 16)) begin tests_failed++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 16)); end
            tests_run++; if (r_data !== 8'h01 || r_valid !== 1'b1) begin tests_failed++; $display("FAIL fill_head[%0d]: got %0h/%b expected 01/1", i, r_data, r_valid); end
        end
        for (int i = 1; i <= 16; i++) begin
            tests_run++; if (r_data !== 8'(i)) begin tests_failed++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, r_data, i); end
            do_read();
            tests_run++; if (count !== 5'(16 - i)) begin tests_failed++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 16 - i); end
            tests_run++; if (almost_empty !== ((16 - i) <= 4)) begin tests_failed++; $display("FAIL drain_ae[%0d]: got %b expected %b", i, almost_empty, ((16 - i) <= 4)); end
        end
        tests_run++; if (empty !== 1'b1 || r_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got empty=%b valid=%b expected 1/0", empty, r_valid); end
        tests_run++; if (underflow !== 1'b0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL drain_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
    endtask

    task automatic test_boundaries();
        do_clr();
        for (int i = 0; i < 16; i++) do_write(8'(8'h20 + i));
        wr = 1'b1; rd = 1'b1; w_data = 8'h77;
        tick();
        wr = 1'b0; rd = 1'b0;
        tests_run++; if (count !== 5'd16 || full !== 1'b1) begin tests_failed++; $display("FAIL full_wrrd_count: got %0d/%b expected 16/1", count, full); end
        tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL full_wrrd_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
        tests_run++; if (r_data !== 8'h21) begin tests_failed++; $display("FAIL full_wrrd_head: got %0h expected 21", r_data); end
        do_write(8'h99);
        tests_run++; if (overflow !== 1'b1 || count !== 5'd16) begin tests_failed++; $display("FAIL full_wr_ovf: got ovf=%b count=%0d expected 1/16", overflow, count); end
        tests_run++; if (r_data !== 8'h21) begin tests_failed++; $display("FAIL full_wr_head: got %0h expected 21", r_data); end
        do_clr();
        wr = 1'b1; rd = 1'b1; w_data = 8'hA5;
        tick();
        wr = 1'b0; rd = 1'b0;
        tests_run++; if (count !== 5'd1 || underflow !== 1'b1) begin tests_failed++; $display("FAIL empty_wrrd: got count=%0d unf=%b expected 1/1", count, underflow); end
        tests_run++; if (r_data !== 8'hA5 || overflow !== 1'b0) begin tests_failed++; $display("FAIL empty_wrrd_data: got %0h ovf=%b expected a5/0", r_data, overflow); end
    endtask

    task automatic test_clr();
        do_clr();
        do_read();
        for (int i = 0; i < 16; i++) do_write(8'(8'h50 + i));
        do_write(8'hFF);
        for (int i = 0; i < 7; i++) do_read();
        tests_run++; if (count !== 5'd9 || overflow !== 1'b1 || underflow !== 1'b1) begin tests_failed++; $display("FAIL clr_setup: got count=%0d ovf=%b unf=%b expected 9/1/1", count, overflow, underflow); end
        clr = 1'b1; wr = 1'b1; w_data = 8'hEE;
        tick();
        clr = 1'b0; wr = 1'b0;
        tests_run++; if (count !== 5'd0 || empty !== 1'b1) begin tests_failed++; $display("FAIL clr_count: got count=%0d empty=%b expected 0/1", count, empty); end
        tests_run++; if (overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL clr_flags: got ovf=%b unf=%b expected 0/0", overflow, underflow); end
        tick();
        tests_run++; if (count !== 5'd0 || almost_empty !== 1'b1) begin tests_failed++; $display("FAIL clr_after: got count=%0d ae=%b expected 0/1", count, almost_empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] exp_d;
        do_clr();
        for (int i = 0; i < 15; i++) begin
            do_write(8'(8'h40 + i));
            q.push_back(8'(8'h40 + i));
        end
        for (int n = 0; n < 40; n++) begin
            exp_d = q[0];
            tests_run++; if (r_data !== exp_d) begin tests_failed++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", n, r_data, exp_d); end
            wr = 1'b1; rd = 1'b1; w_data = 8'(8'h80 + n);
            tick();
            wr = 1'b0; rd = 1'b0;
            void'(q.pop_front());
            q.push_back(8'(8'h80 + n));
            tests_run++; if (count !== 5'd15 || full !== 1'b0) begin tests_failed++; $display("FAIL wrap_count[%0d]: got %0d full=%b expected 15/0", n, count, full); end
        end
        for (int n = 0; n < 15; n++) begin
            exp_d = q.pop_front();
            tests_run++; if (r_data !== exp_d) begin tests_failed++; $display("FAIL wrap_drain[%0d]: got %0h expected %0h", n, r_data, exp_d); end
            do_read();
        end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_tick_gating();
        do_clr();
        wr = 1'b1;
        for (int p = 0; p < 4; p++) begin
            w_data = 8'(8'h60 + p);
            for (int c = 0; c < 16; c++) begin
                s_tick = (c == 0);
                tick();
            end
            tests_run++; if (count !== 5'(p + 1)) begin tests_failed++; $display("FAIL gate_wr[%0d]: got %0d expected %0d", p, count, p + 1); end
        end
        wr = 1'b0; rd = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tests_run++; if (r_data !== 8'(8'h60 + p)) begin tests_failed++; $display("FAIL gate_data[%0d]: got %0h expected %0h", p, r_data, 8'h60 + p); end
            for (int c = 0; c < 16; c++) begin
                s_tick = (c == 0);
                tick();
            end
            tests_run++; if (count !== 5'(3 - p)) begin tests_failed++; $display("FAIL gate_rd[%0d]: got %0d expected %0d", p, count, 3 - p); end
        end
        tests_run++; if (underflow !== 1'b0) begin tests_failed++; $display("FAIL gate_unf: got %b expected 0", underflow); end
        rd = 1'b0; s_tick = 1'b1;
    endtask

    task automatic test_registered();
        do_clr();
        do_write(8'h3C);
        do_write(8'hC3);
        tests_run++; if (r_valid_r !== 1'b0 || count_r !== 5'd2) begin tests_failed++; $display("FAIL reg_idle: got valid=%b count=%0d expected 0/2", r_valid_r, count_r); end
        do_read();
        tests_run++; if (r_data_r !== 8'h3C || r_valid_r !== 1'b1) begin tests_failed++; $display("FAIL reg_rd1: got %0h/%b expected 3c/1", r_data_r, r_valid_r); end
        tick();
        tests_run++; if (r_data_r !== 8'h3C || r_valid_r !== 1'b0) begin tests_failed++; $display("FAIL reg_hold: got %0h/%b expected 3c/0", r_data_r, r_valid_r); end
        s_tick = 1'b0; rd = 1'b1;
        tick();
        tests_run++; if (r_data_r !== 8'h3C || r_valid_r !== 1'b0 || count_r !== 5'd1) begin tests_failed++; $display("FAIL reg_gated: got %0h/%b count=%0d expected 3c/0/1", r_data_r, r_valid_r, count_r); end
        s_tick = 1'b1;
        tick();
        rd = 1'b0;
        tests_run++; if (r_data_r !== 8'hC3 || r_valid_r !== 1'b1) begin tests_failed++; $display("FAIL reg_rd2: got %0h/%b expected c3/1", r_data_r, r_valid_r); end
        do_read();
        tests_run++; if (r_data_r !== 8'hC3 || r_valid_r !== 1'b0 || unf_r !== 1'b1) begin tests_failed++; $display("FAIL reg_underflow: got %0h/%b unf=%b expected c3/0/1", r_data_r, r_valid_r, unf_r); end
    endtask

    task automatic test_reset_mid();
        do_clr();
        for (int i = 0; i < 7; i++) do_write(8'(8'h10 + i));
        do_read();
        do_write(8'h17);
        tests_run++; if (count !== 5'd7 || count_r !== 5'd7) begin tests_failed++; $display("FAIL mid_setup: got %0d/%0d expected 7/7", count, count_r); end
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        tests_run++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL mid_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
        tests_run++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || r_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_flags: got ae=%b af=%b valid=%b expected 1/0/0", almost_empty, almost_full, r_valid); end
        tests_run++; if (r_data_r !== 8'h00 || r_valid_r !== 1'b0 || count_r !== 5'd0) begin tests_failed++; $display("FAIL mid_regmode: got %0h/%b count=%0d expected 00/0/0", r_data_r, r_valid_r, count_r); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        tests_run++; if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin tests_failed++; $display("FAIL mid_after: got count=%0d ovf=%b unf=%b expected 0/0/0", count, overflow, underflow); end
    endtask

    initial begin
        reset_n = 1'b0; s_tick = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        test_reset();
        test_fill_drain();
        test_boundaries();
        test_clr();
        test_wrap();
        test_tick_gating();
        test_registered();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
